// File: rtl/program_memory_arbiter_if.sv
// ============================================================================
// Module   : program_memory_arbiter_if
// Purpose  : Request/response bundle for the fetch and debug ports plus the
//            ROM read port of the program memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface program_memory_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic [DATA_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_error;

    logic                  dbg_req;
    logic [DATA_WIDTH-1:0] dbg_addr;
    logic                  dbg_valid;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic                  dbg_error;

    logic [DATA_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_instruction;

    // Requesters and the ROM model sit on the master side.
    modport master (
        output fetch_req, fetch_addr, dbg_req, dbg_addr, rom_instruction,
        input  fetch_valid, fetch_data, fetch_error,
        input  dbg_valid, dbg_data, dbg_error, rom_addr
    );

    modport slave (
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, rom_instruction,
        output fetch_valid, fetch_data, fetch_error,
        output dbg_valid, dbg_data, dbg_error, rom_addr
    );
endinterface

`default_nettype wire

// File: rtl/program_memory_arbiter.sv
// ============================================================================
// Module   : program_memory_arbiter
// Purpose  : Shares the combinational program-ROM read port between fetch and
//            debug, fetch-priority with a debug starvation guard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_memory_arbiter #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 'h40000,
    parameter int unsigned           STARVE_LIMIT = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    program_memory_arbiter_if.slave bus
);

    localparam int unsigned           c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0]    c_LIMIT = c_CNT_W'(STARVE_LIMIT);
    localparam logic [DATA_WIDTH-1:0] c_DEPTH = DATA_WIDTH'(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DBG   = 2'd2
    } state_t;

    state_t                  state_q,       state_d;
    logic [c_CNT_W-1:0]      starve_cnt_q,  starve_cnt_d;
    logic [DATA_WIDTH-1:0]   last_addr_q,   last_addr_d;
    logic [DATA_WIDTH-1:0]   fetch_data_q,  fetch_data_d;
    logic                    fetch_error_q, fetch_error_d;
    logic [DATA_WIDTH-1:0]   dbg_data_q,    dbg_data_d;
    logic                    dbg_error_q,   dbg_error_d;

    logic                    w_grant_fetch;
    logic                    w_grant_dbg;
    logic [DATA_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_offset;
    logic                    w_sel_error;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    always_comb begin
        w_grant_dbg   = bus.dbg_req && (!bus.fetch_req || (starve_cnt_q == c_LIMIT));
        w_grant_fetch = bus.fetch_req && !w_grant_dbg;

        if (w_grant_dbg) begin
            w_sel_addr = bus.dbg_addr;
        end else if (w_grant_fetch) begin
            w_sel_addr = bus.fetch_addr;
        end else begin
            w_sel_addr = last_addr_q;
        end

        // Below-base addresses wrap to huge offsets; the explicit < test catches them.
        w_offset    = w_sel_addr - BASE_ADDRESS;
        w_sel_error = (w_sel_addr[1:0] != 2'b00)
                   || (w_sel_addr < BASE_ADDRESS)
                   || ((w_offset >> 2) >= c_DEPTH);
        w_sel_data  = w_sel_error ? '0 : bus.rom_instruction;
    end

    always_comb begin
        state_d       = S_IDLE;
        starve_cnt_d  = starve_cnt_q;
        last_addr_d   = last_addr_q;
        fetch_data_d  = fetch_data_q;
        fetch_error_d = fetch_error_q;
        dbg_data_d    = dbg_data_q;
        dbg_error_d   = dbg_error_q;

        if (w_grant_dbg) begin
            state_d     = S_DBG;
            last_addr_d = w_sel_addr;
            dbg_data_d  = w_sel_data;
            dbg_error_d = w_sel_error;
        end else if (w_grant_fetch) begin
            state_d       = S_FETCH;
            last_addr_d   = w_sel_addr;
            fetch_data_d  = w_sel_data;
            fetch_error_d = w_sel_error;
        end

        if (!bus.dbg_req || w_grant_dbg) begin
            starve_cnt_d = '0;
        end else if (w_grant_fetch && (starve_cnt_q != c_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            starve_cnt_q  <= '0;
            last_addr_q   <= BASE_ADDRESS;
            fetch_data_q  <= '0;
            fetch_error_q <= 1'b0;
            dbg_data_q    <= '0;
            dbg_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            last_addr_q   <= last_addr_d;
            fetch_data_q  <= fetch_data_d;
            fetch_error_q <= fetch_error_d;
            dbg_data_q    <= dbg_data_d;
            dbg_error_q   <= dbg_error_d;
        end
    end

    // The owner recorded at the last edge decides which port pulses valid now.
    assign bus.fetch_valid = (state_q == S_FETCH);
    assign bus.dbg_valid   = (state_q == S_DBG);
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_error = fetch_error_q;
    assign bus.dbg_data    = dbg_data_q;
    assign bus.dbg_error   = dbg_error_q;
    assign bus.rom_addr    = w_sel_addr;

endmodule

`default_nettype wire

// File: tb/tb_program_memory_arbiter.sv
// ============================================================================
// Module   : tb_program_memory_arbiter
// Purpose  : Directed self-checking bench for program_memory_arbiter with a
//            cycle-level reference model of grant, response and address rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_memory_arbiter;

    localparam logic [31:0] BASE   = 32'h40000;
    localparam int unsigned DEPTH  = 32;
    localparam int          STARVE = 4;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] rom [0:31];

    program_memory_arbiter_if #(.DATA_WIDTH(32)) bus ();

    program_memory_arbiter #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (DEPTH),
        .BASE_ADDRESS (BASE),
        .STARVE_LIMIT (STARVE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM word i = 0x10000000 + i*0x111; out-of-window reads return garbage.
    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h111;
    end

    always_comb begin
        logic [31:0] off;
        off = bus.rom_addr - BASE;
        if (bus.rom_addr >= BASE && off < 32'd128) bus.rom_instruction = rom[off[6:2]];
        else                                        bus.rom_instruction = 32'hDEAD_BEEF;
    end

    // ---------------- reference model ----------------
    function automatic bit addr_bad(input logic [31:0] a);
        return ((a % 4) != 0) || (a < BASE) || (((a - BASE) / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return addr_bad(a) ? 32'h0 : rom[(a - BASE) / 4];
    endfunction

    int          m_wait = 0;       // cycles debug has been passed over in a row
    logic [31:0] m_last = BASE;
    logic        exp_fv = 1'b0, exp_dv = 1'b0, exp_fe = 1'b0, exp_de = 1'b0;
    logic [31:0] exp_fd = 32'h0, exp_dd = 32'h0;
    logic        m_dbg_wins, m_fetch_wins;
    logic [31:0] m_rom_addr;

    assign m_dbg_wins   = bus.dbg_req && (!bus.fetch_req || m_wait >= STARVE);
    assign m_fetch_wins = bus.fetch_req && !m_dbg_wins;
    assign m_rom_addr   = m_dbg_wins ? bus.dbg_addr : (m_fetch_wins ? bus.fetch_addr : m_last);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wait <= 0;  m_last <= BASE;
            exp_fv <= 1'b0; exp_dv <= 1'b0; exp_fe <= 1'b0; exp_de <= 1'b0;
            exp_fd <= 32'h0; exp_dd <= 32'h0;
        end else begin
            exp_fv <= m_fetch_wins;
            exp_dv <= m_dbg_wins;
            if (m_fetch_wins) begin
                exp_fd <= rom_word(bus.fetch_addr);
                exp_fe <= addr_bad(bus.fetch_addr);
                m_last <= bus.fetch_addr;
            end
            if (m_dbg_wins) begin
                exp_dd <= rom_word(bus.dbg_addr);
                exp_de <= addr_bad(bus.dbg_addr);
                m_last <= bus.dbg_addr;
            end
            if (bus.dbg_req && m_fetch_wins) m_wait <= (m_wait < STARVE) ? m_wait + 1 : STARVE;
            else                             m_wait <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, half a period after the edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, exp_fv});
            check("m_fetch_data",  bus.fetch_data,           exp_fd);
            check("m_fetch_error", {31'b0, bus.fetch_error}, {31'b0, exp_fe});
            check("m_dbg_valid",   {31'b0, bus.dbg_valid},   {31'b0, exp_dv});
            check("m_dbg_data",    bus.dbg_data,             exp_dd);
            check("m_dbg_error",   {31'b0, bus.dbg_error},   {31'b0, exp_de});
            check("m_rom_addr",    bus.rom_addr,             m_rom_addr);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
        bus.dbg_req   = 1'b0; bus.dbg_addr   = 32'h0;
        #1 reset = 1'b0;
        cycle(); cycle();
        check("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
        check("rst_rom_addr",    bus.rom_addr, 32'h40000);
        reset = 1'b1;
        cycle();

        // fetch streaming
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40000;
        cycle();
        check("stream0_valid", {31'b0, bus.fetch_valid}, 32'd1);
        check("stream0_data",  bus.fetch_data, 32'h1000_0000);
        bus.fetch_addr = 32'h40004;
        cycle();
        check("stream1_data",  bus.fetch_data, 32'h1000_0111);
        bus.fetch_addr = 32'h40008;
        cycle();
        check("stream2_data",  bus.fetch_data, 32'h1000_0222);
        check("stream2_dbgv",  {31'b0, bus.dbg_valid}, 32'd0);
        bus.fetch_req = 1'b0;
        cycle();
        check("stream_end_valid", {31'b0, bus.fetch_valid}, 32'd0);

        // error cases
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40002;
        cycle();
        check("misalign_err",  {31'b0, bus.fetch_error}, 32'd1);
        check("misalign_data", bus.fetch_data, 32'h0);
        bus.fetch_addr = 32'h3FFFC;
        cycle();
        check("below_err",     {31'b0, bus.fetch_error}, 32'd1);
        bus.fetch_addr = 32'h40080;
        cycle();
        check("above_err",     {31'b0, bus.fetch_error}, 32'd1);
        check("above_data",    bus.fetch_data, 32'h0);
        bus.fetch_addr = 32'h4007C;
        cycle();
        check("last_err",      {31'b0, bus.fetch_error}, 32'd0);
        check("last_data",     bus.fetch_data, 32'h1000_210F);
        bus.fetch_req = 1'b0;
        cycle();

        // starvation: debug wins on the 5th and 10th edges
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40000;
        bus.dbg_req   = 1'b1; bus.dbg_addr   = 32'h40010;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            check("starve_dbgv",   {31'b0, bus.dbg_valid},   {31'b0, (i == 5 || i == 10)});
            check("starve_fetchv", {31'b0, bus.fetch_valid}, {31'b0, !(i == 5 || i == 10)});
            if (i == 5) check("starve_dbg_data", bus.dbg_data, 32'h1000_0444);
        end
        bus.dbg_req = 1'b0; bus.fetch_addr = 32'h40004;
        cycle();
        bus.fetch_req = 1'b0;
        cycle();

        // debug alone, then idle address hold
        bus.dbg_req = 1'b1; bus.dbg_addr = 32'h40010;
        cycle();
        check("dbg_only_valid", {31'b0, bus.dbg_valid}, 32'd1);
        bus.dbg_req = 1'b0;
        cycle();
        check("dbg_only_end",   {31'b0, bus.dbg_valid}, 32'd0);
        check("idle_rom_addr",  bus.rom_addr, 32'h40010);

        // simultaneous requests with empty counter
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40020;
        bus.dbg_req   = 1'b1; bus.dbg_addr   = 32'h4000C;
        cycle();
        check("simul_fetchv",  {31'b0, bus.fetch_valid}, 32'd1);
        check("simul_fdata",   bus.fetch_data, 32'h1000_0888);
        bus.fetch_req = 1'b0;
        cycle();
        check("simul_dbgv",    {31'b0, bus.dbg_valid}, 32'd1);
        check("simul_ddata",   bus.dbg_data, 32'h1000_0333);
        bus.dbg_req = 1'b0;
        cycle();

        // reset in the middle of a response
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40014;
        cycle();
        check("pre_rst_data", bus.fetch_data, 32'h1000_0555);
        reset = 1'b0; bus.fetch_req = 1'b0;
        #1;
        check("mid_rst_fv",   {31'b0, bus.fetch_valid}, 32'd0);
        check("mid_rst_fd",   bus.fetch_data, 32'h0);
        check("mid_rst_dd",   bus.dbg_data,   32'h0);
        check("mid_rst_addr", bus.rom_addr,   32'h40000);
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        check("post_rst_fv",  {31'b0, bus.fetch_valid}, 32'd0);
        check("post_rst_dv",  {31'b0, bus.dbg_valid},   32'd0);
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h40000;
        cycle();
        check("post_rst_data", bus.fetch_data, 32'h1000_0000);
        bus.fetch_req = 1'b0;
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
